// File: rtl/conv_pkg.sv
// Shared types and constants for the 4x4 convolution scheduler.
package conv_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned OW_DEF = 25;
  localparam int unsigned WIN    = 4;
  localparam int unsigned NTAPS  = WIN * WIN;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CALC,
    OUT,
    FIN
  } state_t;

endpackage

// File: rtl/conv_sched_if.sv
// Feature-memory read port plus result stream of the convolution scheduler.
interface conv_sched_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned OW = 25,
  parameter int unsigned AW = 6
) ();

  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;

  modport master (
    output rd_en, rd_addr, out_valid, out_data,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_valid, out_data,
    output rd_data, out_ready
  );

endinterface

// File: rtl/conv_mac4x4.sv
// Combinational signed 4x4 multiply-accumulate, clamped at zero.
// CONV_SCHED_SAT_EN additionally saturates the result to 0..2^DW-1.
module conv_mac4x4
  import conv_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned OW = OW_DEF
) (
  input  logic [NTAPS*DW-1:0] i_win,
  input  logic [NTAPS*DW-1:0] i_kern,
  output logic [OW-1:0]       o_res
);

  logic signed [DW-1:0]   w_a;
  logic signed [DW-1:0]   w_b;
  logic signed [2*DW-1:0] w_prod;
  logic signed [OW-1:0]   w_acc;

  // Products are formed at 2*DW and sign-extended before summing at OW.
  always_comb begin
    w_a    = '0;
    w_b    = '0;
    w_prod = '0;
    w_acc  = '0;
    for (int i = 0; i < int'(NTAPS); i++) begin
      w_a    = i_win[i*DW +: DW];
      w_b    = i_kern[i*DW +: DW];
      w_prod = (2*DW)'(w_a) * (2*DW)'(w_b);
      w_acc  = w_acc + OW'(w_prod);
    end
  end

  always_comb begin
    o_res = w_acc;
    if (w_acc[OW-1]) begin
      o_res = '0;
    end
`ifdef CONV_SCHED_SAT_EN
    else if (|w_acc[OW-1:DW]) begin
      o_res = OW'({DW{1'b1}});
    end
`endif
  end

endmodule

// File: rtl/conv_sched.sv
// Stride-1 4x4 convolution scheduler: fetches each window, MACs it, streams results.
// Optional output saturation via CONV_SCHED_SAT_EN (see conv_mac4x4).
module conv_sched
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned OW    = OW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [16*DW-1:0]  kernel,
  conv_sched_if.master      bus,
  output logic              busy,
  output logic              done
);

  localparam int unsigned AW = $clog2(IMG_W * IMG_H);
  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  state_t          r_state;
  logic [XW-1:0]   r_ox;
  logic [YW-1:0]   r_oy;
  logic [4:0]      r_fcnt;
  logic [DW-1:0]   r_win [NTAPS];
  logic            r_rd_en;
  logic [AW-1:0]   r_rd_addr;
  logic            r_out_valid;
  logic [OW-1:0]   r_out_data;
  logic            r_busy;
  logic            r_done;

  logic [NTAPS*DW-1:0] w_win;
  logic [OW-1:0]       w_mac;
  logic                w_last_x;
  logic                w_last_y;
  logic [XW-1:0]       w_nx;
  logic [YW-1:0]       w_ny;
  logic [3:0]          w_widx;

  function automatic logic [AW-1:0] tap_addr(input int unsigned oy,
                                             input int unsigned ox,
                                             input int unsigned k);
    return AW'((oy + k / WIN) * IMG_W + ox + (k % WIN));
  endfunction

  always_comb begin
    w_win = '0;
    for (int i = 0; i < int'(NTAPS); i++) begin
      w_win[i*DW +: DW] = r_win[i];
    end
  end

  // Next output position, row-major over the valid window origins.
  always_comb begin
    w_last_x = (r_ox == XW'(IMG_W - WIN));
    w_last_y = (r_oy == YW'(IMG_H - WIN));
    w_nx     = w_last_x ? '0 : r_ox + 1'b1;
    w_ny     = w_last_x ? r_oy + 1'b1 : r_oy;
    w_widx   = 4'(r_fcnt - 5'd1);
  end

  conv_mac4x4 #(.DW(DW), .OW(OW)) u_mac (
    .i_win  (w_win),
    .i_kern (kernel),
    .o_res  (w_mac)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ox        <= '0;
      r_oy        <= '0;
      r_fcnt      <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int i = 0; i < int'(NTAPS); i++) begin
        r_win[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= FETCH;
            r_busy    <= 1'b1;
            r_ox      <= '0;
            r_oy      <= '0;
            r_fcnt    <= '0;
            r_rd_en   <= 1'b1;
            r_rd_addr <= tap_addr(0, 0, 0);
          end
        end
        // Cycle f issues tap f (f<16) and captures tap f-1 (f>=1).
        FETCH: begin
          if (r_fcnt != 5'd0) begin
            r_win[w_widx] <= bus.rd_data;
          end
          if (r_fcnt < 5'd15) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= tap_addr(32'(r_oy), 32'(r_ox), 32'(r_fcnt) + 32'd1);
          end else begin
            r_rd_en   <= 1'b0;
          end
          if (r_fcnt == 5'd16) begin
            r_state <= CALC;
            r_fcnt  <= '0;
          end else begin
            r_fcnt  <= r_fcnt + 5'd1;
          end
        end
        CALC: begin
          r_out_data  <= w_mac;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (w_last_x && w_last_y) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_state   <= FETCH;
              r_ox      <= w_nx;
              r_oy      <= w_ny;
              r_fcnt    <= '0;
              r_rd_en   <= 1'b1;
              r_rd_addr <= tap_addr(32'(w_ny), 32'(w_nx), 0);
            end
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched: a 4x4 instance for single-position frames
// and an 8x8 instance for ordering, back-pressure and mid-frame reset.
module tb_conv_sched;
  import conv_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned OW = 25;
`ifdef CONV_SCHED_SAT_EN
  localparam int unsigned EXP6 = 255;
`else
  localparam int unsigned EXP6 = 258064;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start4 = 1'b0;
  logic             start8 = 1'b0;
  logic [16*DW-1:0] kern4 = '0;
  logic [16*DW-1:0] kern8 = '0;
  logic             busy4, done4, busy8, done8;

  conv_sched_if #(.DW(DW), .OW(OW), .AW(4)) if4 ();
  conv_sched_if #(.DW(DW), .OW(OW), .AW(6)) if8 ();

  conv_sched #(.IMG_W(4), .IMG_H(4), .DW(DW), .OW(OW)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .kernel(kern4),
    .bus(if4), .busy(busy4), .done(done4)
  );

  conv_sched #(.IMG_W(8), .IMG_H(8), .DW(DW), .OW(OW)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .kernel(kern8),
    .bus(if8), .busy(busy8), .done(done8)
  );

  logic [DW-1:0] mem4 [16];
  logic [DW-1:0] mem8 [64];

  // Feature memories: data one cycle after the strobe, filler otherwise.
  always @(posedge clk) begin
    if4.rd_data <= if4.rd_en ? mem4[if4.rd_addr] : 8'hA5;
    if8.rd_data <= if8.rd_en ? mem8[if8.rd_addr] : 8'hA5;
  end

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] q8 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [16*DW-1:0] kfill(input logic [DW-1:0] v);
    logic [16*DW-1:0] k;
    for (int i = 0; i < 16; i++) k[i*DW +: DW] = v;
    return k;
  endfunction

  task automatic run4(input bit spam, output int cyc_done, output int nvalid,
                      output logic [OW-1:0] res);
    nvalid   = 0;
    res      = '0;
    cyc_done = -1;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    chk("first_rden", 32'(if4.rd_en), 1);
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (if4.out_valid) begin
        nvalid++;
        res = if4.out_data;
      end
      start4 = spam && (cyc == 5);
      if (done4) begin
        cyc_done = cyc;
        break;
      end
      @(negedge clk);
    end
    start4 = spam;
    @(negedge clk);
    start4 = 1'b0;
    chk("busy_after_fin", 32'(busy4), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_no_rden", 32'(if4.rd_en | busy4), 0);
    end
  endtask

  task automatic run8(input int stall, input logic [OW-1:0] exp_first, output bit got_done);
    bit stalled;
    stalled  = 1'b0;
    got_done = 1'b0;
    q8.delete();
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (if8.out_valid && stall > 0 && !stalled) begin
        stalled = 1'b1;
        if8.out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("stall_valid", 32'(if8.out_valid), 1);
          chk("stall_data", 32'(if8.out_data), 32'(exp_first));
          chk("stall_no_rden", 32'(if8.rd_en), 0);
        end
        if8.out_ready = 1'b1;
      end
      if (if8.out_valid && if8.out_ready) q8.push_back(if8.out_data);
      if (done8) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic check_q8(input string tag, input int off);
    int idx;
    chk({tag, "_count"}, 32'(q8.size()), 25);
    idx = 0;
    for (int oy = 0; oy < 5; oy++) begin
      for (int ox = 0; ox < 5; ox++) begin
        if (idx < q8.size()) chk(tag, 32'(q8[idx]), 32'(oy * 8 + ox + off));
        idx++;
      end
    end
  endtask

  int            cd, nv, hs;
  logic [OW-1:0] res;
  bit            gd, saw_done;

  initial begin
    if4.out_ready = 1'b1;
    if8.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) mem8[i] = 8'(i);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy4", 32'(busy4), 0);
    chk("rst_outs4", 32'({if4.rd_en, if4.out_valid, done4}), 0);
    chk("rst_outs8", 32'({if8.rd_en, if8.out_valid, busy8, done8}), 0);
    chk("rst_data8", 32'(if8.out_data), 0);
    rst_n = 1'b1;

    // Test 1: single position, all ones
    for (int i = 0; i < 16; i++) mem4[i] = 8'd1;
    kern4 = kfill(8'd1);
    run4(1'b0, cd, nv, res);
    chk("t1_done_latency", 32'(cd), 19);
    chk("t1_nvalid", 32'(nv), 1);
    chk("t1_data", 32'(res), 16);

    // Test 3: negative sum clamps to zero
    for (int i = 0; i < 16; i++) mem4[i] = 8'd5;
    kern4 = kfill(8'hFF);
    run4(1'b0, cd, nv, res);
    chk("t3_nvalid", 32'(nv), 1);
    chk("t3_data", 32'(res), 0);

    // Test 2: identity tap at element 0 reproduces window origins
    kern8 = '0;
    kern8[0 +: DW] = 8'd1;
    run8(0, '0, gd);
    chk("t2_done", 32'(gd), 1);
    check_q8("t2_order", 0);

    // Test 4: back-pressure on first result, tap at element 5 -> pixel (oy+1,ox+1)
    kern8 = '0;
    kern8[5*DW +: DW] = 8'd1;
    run8(10, OW'(9), gd);
    chk("t4_done", 32'(gd), 1);
    check_q8("t4_order", 9);

    // Test 5: reset during fetch of position 3
    kern8 = '0;
    kern8[0 +: DW] = 8'd1;
    hs = 0;
    saw_done = 1'b0;
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (done8) saw_done = 1'b1;
      if (if8.out_valid && if8.out_ready) hs++;
      if (hs == 3 && if8.rd_en) begin
        repeat (4) @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    chk("t5_reached_pos3", 32'(hs), 3);
    chk("t5_mid_fetch", 32'(if8.rd_en), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", 32'({if8.rd_en, if8.out_valid, busy8, done8}), 0);
    chk("t5_rst_data", 32'(if8.out_data), 0);
    repeat (2) @(negedge clk);
    if (done8) saw_done = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    if (done8 | busy8) saw_done = 1'b1;
    chk("t5_no_done", 32'(saw_done), 0);
    run8(0, '0, gd);
    chk("t5_rerun_done", 32'(gd), 1);
    check_q8("t5_rerun", 0);

    // Test 6: large positive sum; start pulses while busy and in FIN
    for (int i = 0; i < 16; i++) mem4[i] = 8'd127;
    kern4 = kfill(8'd127);
    run4(1'b1, cd, nv, res);
    chk("t6_done_latency", 32'(cd), 19);
    chk("t6_nvalid", 32'(nv), 1);
    chk("t6_data", 32'(res), EXP6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
